// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the RV32I core.
// Holds the ResultSrc and ALU control encodings plus the execute-stage
// control bundle ctrl_e_t. The EX/MEM and MEM/WB registers reuse the bundle.
package pipe_pkg;

  // ResultSrc: selects the writeback source.
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;
  localparam logic [1:0] RESULT_IMM = 2'b11;

  // ALU control encodings.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] funct3;
  } ctrl_e_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when the instruction in execute is a valid load that writes a
// nonzero rd, and the valid decode instruction reads that rd.
// The rs2 match is conservative: it is applied even when rs2 is unused.
// Ports: execute-stage valid/reg_write/result_src/rd, decode-stage
// valid/rs1/rs2, and hazard_o.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  valid_e_i,
  input  logic                  reg_write_e_i,
  input  logic [1:0]            result_src_e_i,
  input  logic [REG_ADDR_W-1:0] rd_e_i,
  input  logic                  valid_d_i,
  input  logic [REG_ADDR_W-1:0] rs1_d_i,
  input  logic [REG_ADDR_W-1:0] rs2_d_i,
  output logic                  hazard_o
);

  logic is_load_e;
  logic rd_match;

  assign is_load_e = valid_e_i & reg_write_e_i & (result_src_e_i == RESULT_MEM)
                   & (rd_e_i != '0);
  assign rd_match  = (rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i);
  assign hazard_o  = is_load_e & valid_d_i & rd_match;

endmodule

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register.
// Registers the decode control and data fields into the execute stage.
// Adds a valid bit, a hold control (stall_i) and a kill control (flush_i).
// On a load-use hazard it inserts a bubble by itself and counts the bubble
// in a saturating counter.
// Per-edge priority: rst > flush (bubble) > stall (hold) > hazard (bubble,
// count) > load.
// Ports: *_d_i are the decode inputs and *_e_o their registered copies.
// load_use_stall_o asks fetch/decode to hold this cycle.
// bubble_cnt_o is the hazard-bubble count.
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_d_i,
  input  logic                  reg_write_d_i,
  input  logic [1:0]            result_src_d_i,
  input  logic                  mem_write_d_i,
  input  logic [3:0]            alu_ctrl_d_i,
  input  logic                  alu_src_d_i,
  input  logic [2:0]            funct3_d_i,
  input  logic [DATA_WIDTH-1:0] rd1_d_i,
  input  logic [DATA_WIDTH-1:0] rd2_d_i,
  input  logic [REG_ADDR_W-1:0] rs1_d_i,
  input  logic [REG_ADDR_W-1:0] rs2_d_i,
  input  logic [REG_ADDR_W-1:0] rd_d_i,
  input  logic [DATA_WIDTH-1:0] imm_ext_d_i,
  input  logic [DATA_WIDTH-1:0] pc_d_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_d_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  valid_e_o,
  output logic                  reg_write_e_o,
  output logic [1:0]            result_src_e_o,
  output logic                  mem_write_e_o,
  output logic [3:0]            alu_ctrl_e_o,
  output logic                  alu_src_e_o,
  output logic [2:0]            funct3_e_o,
  output logic [DATA_WIDTH-1:0] rd1_e_o,
  output logic [DATA_WIDTH-1:0] rd2_e_o,
  output logic [REG_ADDR_W-1:0] rs1_e_o,
  output logic [REG_ADDR_W-1:0] rs2_e_o,
  output logic [REG_ADDR_W-1:0] rd_e_o,
  output logic [DATA_WIDTH-1:0] imm_ext_e_o,
  output logic [DATA_WIDTH-1:0] pc_e_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_e_o,
  output logic                  load_use_stall_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  ctrl_e_t               ctrl_in, ctrl_q, ctrl_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d, pc_q, pc_d, pc4_q, pc4_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hazard;

  assign ctrl_in = '{reg_write:  reg_write_d_i,
                     result_src: result_src_d_i,
                     mem_write:  mem_write_d_i,
                     alu_ctrl:   alu_ctrl_d_i,
                     alu_src:    alu_src_d_i,
                     funct3:     funct3_d_i};

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .valid_e_i      (valid_q),
    .reg_write_e_i  (ctrl_q.reg_write),
    .result_src_e_i (ctrl_q.result_src),
    .rd_e_i         (rd_q),
    .valid_d_i      (valid_d_i),
    .rs1_d_i        (rs1_d_i),
    .rs2_d_i        (rs2_d_i),
    .hazard_o       (hazard)
  );

  // A stall or flush already holds or kills the stage, so no extra request
  // to freeze decode is needed.
  assign load_use_stall_o = hazard & ~flush_i & ~stall_i;

  always_comb begin
    // Default: hold.
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    cnt_d   = cnt_q;
    if (flush_i || (!stall_i && hazard)) begin
      // Bubble: data fields are zeroed too, which keeps waveforms clean.
      valid_d = 1'b0;
      ctrl_d  = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      imm_d   = '0;
      pc_d    = '0;
      pc4_d   = '0;
      if (!flush_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (!stall_i) begin
      valid_d = valid_d_i;
      ctrl_d  = ctrl_in;
      rd1_d   = rd1_d_i;
      rd2_d   = rd2_d_i;
      rs1_d   = rs1_d_i;
      rs2_d   = rs2_d_i;
      rd_d    = rd_d_i;
      imm_d   = imm_ext_d_i;
      pc_d    = pc_d_i;
      pc4_d   = pc_plus4_d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_e_o      = valid_q;
  assign reg_write_e_o  = ctrl_q.reg_write;
  assign result_src_e_o = ctrl_q.result_src;
  assign mem_write_e_o  = ctrl_q.mem_write;
  assign alu_ctrl_e_o   = ctrl_q.alu_ctrl;
  assign alu_src_e_o    = ctrl_q.alu_src;
  assign funct3_e_o     = ctrl_q.funct3;
  assign rd1_e_o        = rd1_q;
  assign rd2_e_o        = rd2_q;
  assign rs1_e_o        = rs1_q;
  assign rs2_e_o        = rs2_q;
  assign rd_e_o         = rd_q;
  assign imm_ext_e_o    = imm_q;
  assign pc_e_o         = pc_q;
  assign pc_plus4_e_o   = pc4_q;
  assign bubble_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Randomised and directed bench for id_ex_pipe.
// Two instances share one input bundle: the default build (CNT_W=16) and a
// narrow-counter build (CNT_W=2) for saturation. Both are compared against
// an instruction-level reference model.
module tb_id_ex_pipe;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [1:0]  rsrc;
    logic        mw;
    logic [3:0]  alu;
    logic        asrc;
    logic [2:0]  f3;
    logic [31:0] rd1, rd2;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc, pc4;
  } slot_t;

  logic clk = 1'b0;
  logic rst, stall, flush;
  slot_t din;

  // Reference model state: the instruction sitting in execute, plus counters.
  slot_t m;
  int    cnt16, cnt2;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  slot_t      obs, obs_s;
  logic       lus, lus_s;
  logic [15:0] cnt_o;
  logic [1:0]  cnt_o_s;

  id_ex_pipe dut (
    .clk(clk), .rst(rst),
    .valid_d_i(din.valid), .reg_write_d_i(din.rw), .result_src_d_i(din.rsrc),
    .mem_write_d_i(din.mw), .alu_ctrl_d_i(din.alu), .alu_src_d_i(din.asrc),
    .funct3_d_i(din.f3), .rd1_d_i(din.rd1), .rd2_d_i(din.rd2),
    .rs1_d_i(din.rs1), .rs2_d_i(din.rs2), .rd_d_i(din.rd),
    .imm_ext_d_i(din.imm), .pc_d_i(din.pc), .pc_plus4_d_i(din.pc4),
    .stall_i(stall), .flush_i(flush),
    .valid_e_o(obs.valid), .reg_write_e_o(obs.rw), .result_src_e_o(obs.rsrc),
    .mem_write_e_o(obs.mw), .alu_ctrl_e_o(obs.alu), .alu_src_e_o(obs.asrc),
    .funct3_e_o(obs.f3), .rd1_e_o(obs.rd1), .rd2_e_o(obs.rd2),
    .rs1_e_o(obs.rs1), .rs2_e_o(obs.rs2), .rd_e_o(obs.rd),
    .imm_ext_e_o(obs.imm), .pc_e_o(obs.pc), .pc_plus4_e_o(obs.pc4),
    .load_use_stall_o(lus), .bubble_cnt_o(cnt_o)
  );

  id_ex_pipe #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .valid_d_i(din.valid), .reg_write_d_i(din.rw), .result_src_d_i(din.rsrc),
    .mem_write_d_i(din.mw), .alu_ctrl_d_i(din.alu), .alu_src_d_i(din.asrc),
    .funct3_d_i(din.f3), .rd1_d_i(din.rd1), .rd2_d_i(din.rd2),
    .rs1_d_i(din.rs1), .rs2_d_i(din.rs2), .rd_d_i(din.rd),
    .imm_ext_d_i(din.imm), .pc_d_i(din.pc), .pc_plus4_d_i(din.pc4),
    .stall_i(stall), .flush_i(flush),
    .valid_e_o(obs_s.valid), .reg_write_e_o(obs_s.rw), .result_src_e_o(obs_s.rsrc),
    .mem_write_e_o(obs_s.mw), .alu_ctrl_e_o(obs_s.alu), .alu_src_e_o(obs_s.asrc),
    .funct3_e_o(obs_s.f3), .rd1_e_o(obs_s.rd1), .rd2_e_o(obs_s.rd2),
    .rs1_e_o(obs_s.rs1), .rs2_e_o(obs_s.rs2), .rd_e_o(obs_s.rd),
    .imm_ext_e_o(obs_s.imm), .pc_e_o(obs_s.pc), .pc_plus4_e_o(obs_s.pc4),
    .load_use_stall_o(lus_s), .bubble_cnt_o(cnt_o_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // A load in execute blocks a decode reader of the same nonzero register.
  function automatic bit model_hazard();
    return m.valid && m.rw && m.rsrc == 2'b01 && m.rd != 0 && din.valid &&
           (m.rd == din.rs1 || m.rd == din.rs2);
  endfunction

  task automatic model_edge();
    bit h = model_hazard();
    if (rst) begin
      m = '0; cnt16 = 0; cnt2 = 0;
    end else if (flush) m = '0;
    else if (stall) ;
    else if (h) begin
      m = '0;
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
    end else m = din;
  endtask

  // One clock: check the combinational request, take the edge, check state.
  task automatic cyc();
    #1;
    chk("load_use_stall", {63'd0, lus}, {63'd0, (model_hazard() && !flush && !stall)});
    chk("load_use_stall_s", {63'd0, lus_s}, {63'd0, (model_hazard() && !flush && !stall)});
    @(posedge clk);
    model_edge();
    #1;
    chk("e_stage_lo", obs[63:0], m[63:0]);
    chk("e_stage_hi", {1'b0, obs[$bits(slot_t)-1:64]}, {1'b0, m[$bits(slot_t)-1:64]});
    chk("e_stage_s", {1'b0, obs_s[$bits(slot_t)-1:64]} ^ obs_s[63:0],
                     {1'b0, m[$bits(slot_t)-1:64]} ^ m[63:0]);
    chk("bubble_cnt", {48'd0, cnt_o}, cnt16);
    chk("bubble_cnt_s", {62'd0, cnt_o_s}, cnt2);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
  endtask

  function automatic slot_t mk(bit v, bit rw, logic [1:0] rs, logic [4:0] rd,
                               logic [4:0] r1, logic [4:0] r2);
    slot_t s = '0;
    s.valid = v; s.rw = rw; s.rsrc = rs; s.rd = rd; s.rs1 = r1; s.rs2 = r2;
    return s;
  endfunction

  int sat_exp[5];

  initial begin
    sat_exp = '{1, 2, 3, 3, 3};
    stall = 1'b0; flush = 1'b0;
    din = '1;
    rst = 1'b1;
    m = '0; cnt16 = 0; cnt2 = 0;
    @(posedge clk); #1;

    // Reset with all decode inputs nonzero.
    do_reset();
    chk("rst_valid", {63'd0, obs.valid}, 0);
    chk("rst_pc", {32'd0, obs.pc}, 0);
    chk("rst_cnt", {48'd0, cnt_o}, 0);

    // Plain load.
    din = mk(1, 1, 2'b00, 5'd5, 5'd1, 5'd2);
    din.rd1 = 32'hDEADBEEF; din.pc = 32'h100;
    cyc();
    chk("load_rd", {59'd0, obs.rd}, 5);
    chk("load_rd1", {32'd0, obs.rd1}, 64'hDEADBEEF);
    chk("load_pc", {32'd0, obs.pc}, 64'h100);
    chk("load_valid", {63'd0, obs.valid}, 1);

    // Load-use on rs1.
    do_reset();
    din = mk(1, 1, 2'b01, 5'd7, 5'd0, 5'd0);
    cyc();
    din = mk(1, 1, 2'b00, 5'd3, 5'd7, 5'd9);
    #1 chk("lu_req", {63'd0, lus}, 1);
    cyc();
    chk("lu_bubble_valid", {63'd0, obs.valid}, 0);
    chk("lu_bubble_rw", {63'd0, obs.rw}, 0);
    chk("lu_cnt", {48'd0, cnt_o}, 1);
    cyc();
    chk("lu_dep_loads", {59'd0, obs.rs1}, 7);
    chk("lu_dep_valid", {63'd0, obs.valid}, 1);

    // Load to x0, and a non-load producer.
    do_reset();
    din = mk(1, 1, 2'b01, 5'd0, 5'd0, 5'd0);
    cyc();
    din = mk(1, 1, 2'b00, 5'd4, 5'd0, 5'd0);
    #1 chk("x0_req", {63'd0, lus}, 0);
    cyc();
    chk("x0_no_bubble", {63'd0, obs.valid}, 1);
    din = mk(1, 1, 2'b00, 5'd7, 5'd1, 5'd1);
    cyc();
    din = mk(1, 1, 2'b00, 5'd8, 5'd1, 5'd7);
    #1 chk("alu_req", {63'd0, lus}, 0);
    cyc();
    chk("alu_cnt", {48'd0, cnt_o}, 0);

    // Stall hold, then stall+flush.
    din = mk(1, 1, 2'b00, 5'd6, 5'd1, 5'd2); din.pc = 32'h200;
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din.pc = 32'h300 + 32'(i * 4);
      cyc();
      chk("stall_pc", {32'd0, obs.pc}, 64'h200);
    end
    flush = 1'b1;
    cyc();
    chk("flush_valid", {63'd0, obs.valid}, 0);
    chk("flush_cnt", {48'd0, cnt_o}, 0);
    stall = 1'b0; flush = 1'b0;

    // Saturation of the 2-bit counter: a self-dependent load repeats.
    do_reset();
    din = mk(1, 1, 2'b01, 5'd7, 5'd7, 5'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i % 2 == 1) chk("sat_cnt_s", {62'd0, cnt_o_s}, sat_exp[i/2]);
    end

    // Random traffic with narrow register indices to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      din = slot_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      din.rs1 = 5'($urandom_range(0, 3));
      din.rs2 = 5'($urandom_range(0, 3));
      din.rd  = 5'($urandom_range(0, 3));
      din.rsrc = ($urandom_range(0, 1) == 0) ? 2'b01 : din.rsrc;
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 14) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
